// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage RV32I core: stalls, flushes,
// operand forwarding, data-memory wait tracking with timeout. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [WCNT_W-1:0]   wcnt_r, wcnt_s;
  logic                timeout_r;
  logic                mem_stall_s;
  logic                lw_stall_s;

  // MEM result has priority over WB; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic we_m, input logic [4:0] rd_w,
                                         input logic we_w);
    logic [1:0] sel;
    if ((rs != 5'd0) && we_m && (rs == rd_m)) begin
      sel = 2'b10;
    end else if ((rs != 5'd0) && we_w && (rs == rd_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RUN;
      wcnt_r    <= {WCNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      wcnt_r    <= wcnt_s;
      timeout_r <= timeout_r | (state_s == ERR);
    end
  end

  // Next-state logic for the data-memory wait tracker
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_s = MEM_WAIT;
          wcnt_s  = WCNT_W'(32'd1);
        end else begin
          state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_s = RUN;
          wcnt_s  = {WCNT_W{1'b0}};
        end else if (wcnt_r == WCNT_W'(MAX_WAIT)) begin
          state_s = ERR;
        end else begin
          wcnt_s = wcnt_r + WCNT_W'(32'd1);
        end
      end
      ERR: begin
        state_s = ERR;
      end
      default: begin
        state_s = RUN;
        wcnt_s  = {WCNT_W{1'b0}};
      end
    endcase
  end

  // Hazard detection and pipeline control outputs
  always_comb begin
    mem_stall_s = 1'b0;
    case (state_r)
      RUN:      mem_stall_s = MemReqM & ~MemReadyM;
      MEM_WAIT: mem_stall_s = ~MemReadyM;
      ERR:      mem_stall_s = 1'b1;
      default:  mem_stall_s = 1'b1;
    endcase

    lw_stall_s = ResultSrcE0 & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));

    StallF = mem_stall_s | lw_stall_s;
    StallD = mem_stall_s | lw_stall_s;
    StallE = mem_stall_s;
    StallM = mem_stall_s;
    // A redirect held in a stalled EX fires only once memory releases
    FlushD = PCSrcE & ~mem_stall_s;
    FlushE = (lw_stall_s | PCSrcE) & ~mem_stall_s;
    FlushW = mem_stall_s;

    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  assign MemTimeout = timeout_r;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall and redirect counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (StallF && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (PCSrcE && FlushD && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign StallCnt = stall_cnt_r;
  assign FlushCnt = flush_cnt_r;
`else
  assign StallCnt = {CNT_W{1'b0}};
  assign FlushCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It generates the stall, flush and forwarding controls for the IF, ID, EX, MEM and WB stage registers. It resolves load-use hazards, control redirects and multi-cycle data-memory waits, and it latches a fatal timeout when data memory never responds.

## Interface
- `MAX_WAIT`, default 255: longest data-memory wait, in cycles, before timeout; must be ≥1.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: core clock.
- `rst` in 1: reset; asynchronous, active-high.
- `Rs1D`, `Rs2D` in 5: source registers of the instruction in ID.
- `Rs1E`, `Rs2E`, `RdE` in 5: source and destination registers of the instruction in EX.
- `ResultSrcE0` in 1: the instruction in EX is a load.
- `PCSrcE` in 1: the instruction in EX is a taken branch or jump.
- `RdM` in 5, `RegWriteM` in 1: destination register and write enable of the instruction in MEM.
- `RdW` in 5, `RegWriteW` in 1: destination register and write enable of the instruction in WB.
- `MemReqM` in 1: the instruction in MEM is accessing data memory.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `FlushD`, `FlushE`, `FlushW` out 1: insert a bubble into IF/ID, ID/EX and MEM/WB.
- `ForwardAE`, `ForwardBE` out 2: EX operand select; 00 = register file, 10 = MEM result, 01 = WB result.
- `MemTimeout` out 1: sticky fatal flag.
- `StallCnt`, `FlushCnt` out `CNT_W`: performance counters.

## Operation
- FSM states are RUN, MEM_WAIT and ERR. Reset state is RUN.
- Wait counter `wcnt` is $clog2(MAX_WAIT+1) bits wide and resets to 0.
- FSM transitions:
  - RUN: if `MemReqM & !MemReadyM`, go to MEM_WAIT with `wcnt`←1.
  - MEM_WAIT: if `MemReadyM`, go to RUN with `wcnt`←0. Otherwise, if `wcnt==MAX_WAIT`, go to ERR. Otherwise `wcnt`++.
  - ERR: terminal until `rst`; `MemTimeout`=1.
- `memStall` = (RUN & `MemReqM` & !`MemReadyM`) | (MEM_WAIT & !`MemReadyM`) | ERR.
- `lwStall` = `ResultSrcE0` & `RdE`≠0 & (`Rs1D`==`RdE` | `Rs2D`==`RdE`).
- Stall outputs:
  - `StallF` = `StallD` = `memStall` | `lwStall`.
  - `StallE` = `StallM` = `memStall`.
- Flush outputs:
  - `FlushD` = `PCSrcE` & !`memStall`.
  - `FlushE` = (`lwStall` | `PCSrcE`) & !`memStall`.
  - `FlushW` = `memStall`, so a stalled MEM instruction never writes back twice.
- Forwarding for operand A:
  - `ForwardAE`=10 if `Rs1E`≠0 & `RegWriteM` & `Rs1E`==`RdM`.
  - Otherwise 01 if `Rs1E`≠0 & `RegWriteW` & `Rs1E`==`RdW`.
  - Otherwise 00. MEM has priority over WB.
- `ForwardBE` uses the same rules with `Rs2E`.
- Forwarding is evaluated every cycle, including during `memStall`.

## Timing
- All stall, flush and forward outputs are combinational in the current inputs and state, with zero latency.
- `MemTimeout`, `StallCnt` and `FlushCnt` are registered. Reset value of each is 0.
- While `rst` is high the state is RUN, so combinational outputs follow the RUN equations.
- Memory handshake: an access completes in the first cycle `MemReadyM`=1. That cycle has `memStall`=0, and the pipeline advances at the next edge.
- A zero-wait access (`MemReadyM`=1 in the request cycle) causes no stall and no FSM transition.
- Timeout: exactly MAX_WAIT+1 consecutive not-ready cycles cause `MemTimeout`=1 from the following cycle onward. All stalls then stay asserted until reset.
- Redirect during a memory wait: `PCSrcE` is held because EX is stalled. `FlushD`/`FlushE` stay suppressed and fire in the release cycle.
- Load-use together with redirect: `FlushE`=1 and `FlushD`=1. The redirect flushes the younger instructions, and the stall on F/D is harmless.
- `rst` asserted mid-wait returns the block to RUN at once. `wcnt` and `MemTimeout` clear asynchronously.

## Configuration
- Macro `HAZARD_PERF_EN`.
- When defined:
  - `StallCnt` increments on every cycle with `StallF`=1.
  - `FlushCnt` increments on every cycle with `PCSrcE` & `FlushD`.
  - Both counters saturate at all-ones and reset to 0.
- When not defined: both ports remain present and are tied to 0, and no counter flops are built.

## Test plan
- **Load-use:** `ResultSrcE0`=1, `RdE`=5, `Rs1D`=5 → `StallF`=`StallD`=1 and `FlushE`=1 for one cycle. With `RdE`=0 → no stall.
- **Forward priority:** `Rs1E`=7, `RdM`=`RdW`=7, both write enables 1 → `ForwardAE`=10. With `RegWriteM`=0 → 01. With `Rs1E`=0 → 00.
- **Memory wait:** `MemReqM`=1, `MemReadyM` low for 3 cycles, then high → `StallF`..`StallM`=1 and `FlushW`=1 for exactly 3 cycles, then all 0. State returns to RUN.
- **Redirect during wait:** `PCSrcE`=1 throughout a 2-cycle wait → `FlushD`/`FlushE` are 0 during the wait and 1 in the release cycle.
- **Timeout:** `MAX_WAIT`=4, `MemReadyM` held 0 → `MemTimeout` rises after 5 not-ready cycles and stays high. Asserting `rst` clears it immediately.
- **Perf counters** (`HAZARD_PERF_EN` defined): 3-cycle wait plus 1 load-use stall plus 1 redirect → `StallCnt`=4, `FlushCnt`=1.
